// File: rtl/joybus_pkg.sv
// Shared JOYBUS definitions: receiver state encoding, error codes and
// bit-period helper. Also used by the transmit side.
package joybus_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_WAIT_LOW,
    RX_CNT_LOW,
    RX_CNT_HIGH,
    RX_SHIFT,
    RX_STOP_LOW,
    RX_DONE
  } rx_state_t;

  typedef enum logic [1:0] {
    JB_ERR_OK      = 2'b00,
    JB_ERR_DATA_TO = 2'b01,
    JB_ERR_STOP_TO = 2'b10
  } rx_err_t;

  // Nominal JOYBUS bit period is 4 us.
  function automatic int bit_cyc(input int clk_per_us);
    return 4 * clk_per_us;
  endfunction

endpackage

// File: rtl/joybus_line_filter.sv
// Pad-side conditioning for the JOYBUS line: two-flop synchroniser followed
// by a glitch filter that only accepts a new level after it has been stable
// for GLITCH_CYC cycles. Total latency is 2+GLITCH_CYC cycles.
module joybus_line_filter #(
  parameter int GLITCH_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic line
);

  localparam int GW = (GLITCH_CYC < 2) ? 1 : $clog2(GLITCH_CYC + 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [GW-1:0] hold_cnt;

  // Synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let each flop sample the previous
      // stage's old value, which is what makes this a two-stage chain.
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

  // Glitch filter: count consecutive cycles of disagreement, adopt the new
  // level once it has persisted long enough; any return to agreement restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line     <= 1'b1;
      hold_cnt <= '0;
    end else if (sync_q2 == line) begin
      hold_cnt <= '0;
    end else if (hold_cnt == GW'(GLITCH_CYC - 1)) begin
      line     <= sync_q2;
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/joybus_rx_multi.sv
// JOYBUS receive engine: measures the low and high phase of every data bit on
// the filtered line, votes each bit by duty (longer high = 1, tie = 0),
// checks the controller stop bit and reports status and received-bit count.
module joybus_rx_multi
  import joybus_pkg::*;
#(
  parameter int CLK_PER_US = 25,
  parameter int MAX_BITS   = 64,
  parameter int GLITCH_CYC = 2,
  parameter int TO_BITS    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          jb_rx,
  input  logic                          rx_start,
  input  logic                          rx_abort,
  input  logic [$clog2(MAX_BITS+1)-1:0] rx_len,
  output logic                          rx_busy,
  output logic                          rx_done,
  output logic [1:0]                    rx_err,
  output logic [$clog2(MAX_BITS+1)-1:0] rx_bits,
  output logic [MAX_BITS-1:0]           rx_data
);

  localparam int BIT_CYC = bit_cyc(CLK_PER_US);
  localparam int TO_CYC  = TO_BITS * BIT_CYC;
  localparam int CW      = $clog2(TO_CYC + 1);
  localparam int LW      = $clog2(MAX_BITS + 1);

  rx_state_t     state, state_nxt;
  logic          line;
  logic [CW-1:0] cyc;
  logic [CW-1:0] low_cnt;
  logic [CW-1:0] high_cnt;
  logic [LW-1:0] len_q;

  logic          cyc_clr, cyc_ld1, ld_low, ld_high, do_shift, do_start, set_err;
  rx_err_t       err_val;
  logic          cyc_at_to;
  logic          last_bit;

  joybus_line_filter #(
    .GLITCH_CYC(GLITCH_CYC)
  ) u_filter (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (jb_rx),
    .line (line)
  );

  assign cyc_at_to = (cyc == CW'(TO_CYC));
  assign last_bit  = ((rx_bits + LW'(1)) == len_q);
  assign rx_busy   = (state != RX_IDLE);
  assign rx_done   = (state == RX_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath control. Abort beats start, start beats every
  // state transition. Timeout is checked before the line so that a phase
  // lasting TO_CYC cycles is always reported as a timeout.
  always_comb begin
    // NOTE: every output of this block gets a default here; a path that
    // leaves one unassigned would infer a latch.
    state_nxt = state;
    cyc_clr   = 1'b0;
    cyc_ld1   = 1'b0;
    ld_low    = 1'b0;
    ld_high   = 1'b0;
    do_shift  = 1'b0;
    do_start  = 1'b0;
    set_err   = 1'b0;
    err_val   = JB_ERR_OK;
    if (rx_abort) begin
      state_nxt = RX_IDLE;
    end else if (rx_start) begin
      do_start  = 1'b1;
      cyc_clr   = 1'b1;
      state_nxt = (rx_len == '0) ? RX_DONE : RX_WAIT_LOW;
    end else begin
      unique case (state)
        RX_IDLE: ;
        RX_WAIT_LOW, RX_CNT_LOW, RX_CNT_HIGH: begin
          if (cyc_at_to) begin
            state_nxt = RX_DONE;
            set_err   = 1'b1;
            err_val   = JB_ERR_DATA_TO;
          end else if (state == RX_WAIT_LOW && !line) begin
            state_nxt = RX_CNT_LOW;
            cyc_ld1   = 1'b1;
          end else if (state == RX_CNT_LOW && line) begin
            state_nxt = RX_CNT_HIGH;
            ld_low    = 1'b1;
            cyc_ld1   = 1'b1;
          end else if (state == RX_CNT_HIGH && !line) begin
            // The falling edge already belongs to the next low phase; the
            // counter restarts at 1 and keeps running through SHIFT.
            state_nxt = RX_SHIFT;
            ld_high   = 1'b1;
            cyc_ld1   = 1'b1;
          end
        end
        RX_SHIFT: begin
          do_shift  = 1'b1;
          state_nxt = last_bit ? RX_STOP_LOW : RX_CNT_LOW;
        end
        RX_STOP_LOW: begin
          if (cyc_at_to) begin
            state_nxt = RX_DONE;
            set_err   = 1'b1;
            err_val   = JB_ERR_STOP_TO;
          end else if (line) begin
            state_nxt = RX_DONE;
          end
        end
        RX_DONE: state_nxt = RX_IDLE;
        default: state_nxt = RX_IDLE;
      endcase
    end
  end

  // Phase counter, captured phase lengths, shift register and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc      <= '0;
      low_cnt  <= '0;
      high_cnt <= '0;
      len_q    <= '0;
      rx_bits  <= '0;
      rx_data  <= '0;
      rx_err   <= JB_ERR_OK;
    end else begin
      if (cyc_clr)             cyc <= '0;
      else if (cyc_ld1)        cyc <= CW'(1);
      else if (!cyc_at_to)     cyc <= cyc + 1'b1;

      if (ld_low)  low_cnt  <= cyc;
      if (ld_high) high_cnt <= cyc;

      if (do_start) begin
        len_q   <= rx_len;
        rx_data <= '0;
        rx_bits <= '0;
        rx_err  <= JB_ERR_OK;
      end
      if (do_shift) begin
        rx_data <= {rx_data[MAX_BITS-2:0], (high_cnt > low_cnt)};
        rx_bits <= rx_bits + 1'b1;
      end
      if (set_err) rx_err <= err_val;
    end
  end

endmodule

// File: tb/tb_joybus_rx_multi.sv
// Scoreboard bench for joybus_rx_multi: frames are described as lists of
// (low, high) phase lengths plus an optional stop-low length; a reference
// model derives the expected data/count/error from that description, the
// expectation is queued, and a negedge monitor checks every rx_done pulse.
module tb_joybus_rx_multi;

  localparam int MAX_BITS = 64;
  localparam int LW       = 7;
  localparam int TO_CYC   = 200;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] bits;
    logic [1:0]  err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          jb_rx = 1'b1;
  logic          rx_start = 1'b0;
  logic          rx_abort = 1'b0;
  logic [LW-1:0] rx_len = '0;
  logic          rx_busy;
  logic          rx_done;
  logic [1:0]    rx_err;
  logic [LW-1:0] rx_bits;
  logic [MAX_BITS-1:0] rx_data;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  int   frame_lo[$];
  int   frame_hi[$];
  int   stop_len;

  joybus_rx_multi dut (
    .clk(clk), .rst_n(rst_n), .jb_rx(jb_rx), .rx_start(rx_start),
    .rx_abort(rx_abort), .rx_len(rx_len), .rx_busy(rx_busy),
    .rx_done(rx_done), .rx_err(rx_err), .rx_bits(rx_bits), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: each bit's value is its high length beating its low length;
  // a bit only counts once the following low edge arrives; the frame ends
  // at the requested length, or with a data timeout when the line stays high.
  function automatic exp_t model(input int len);
    exp_t e;
    int   n;
    e = '0;
    n = frame_lo.size();
    if (len == 0) return e;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1 && stop_len == 0) begin
        e.err = 2'b01;
        return e;
      end
      e.data = (e.data << 1) | 64'(frame_hi[i] > frame_lo[i]);
      e.bits = e.bits + 1;
      if (e.bits == len) begin
        e.err = (stop_len >= TO_CYC) ? 2'b10 : 2'b00;
        return e;
      end
    end
    e.err = 2'b01;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic start_frame(input int len);
    rx_len   = LW'(len);
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
  endtask

  task automatic drive_bits(input bit glitch);
    for (int i = 0; i < frame_lo.size(); i++) begin
      jb_rx = 1'b0;
      wait_cyc(frame_lo[i]);
      jb_rx = 1'b1;
      if (glitch) begin
        wait_cyc(frame_hi[i] / 2);
        jb_rx = 1'b0;
        tick();
        jb_rx = 1'b1;
        wait_cyc(frame_hi[i] - frame_hi[i] / 2 - 1);
      end else begin
        wait_cyc(frame_hi[i]);
      end
    end
  endtask

  task automatic drive_stop();
    if (stop_len > 0) begin
      jb_rx = 1'b0;
      wait_cyc(stop_len);
    end
    jb_rx = 1'b1;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 800 && done_cnt < target; i++) tick();
    check("done_count", 64'(done_cnt), 64'(target));
    if (done_cnt < target) exp_q.delete();
    wait_cyc(12);
  endtask

  task automatic rand_pairs(input int n);
    frame_lo.delete();
    frame_hi.delete();
    for (int i = 0; i < n; i++) begin
      frame_lo.push_back(int'($urandom_range(20, 80)));
      frame_hi.push_back(int'($urandom_range(20, 80)));
    end
  endtask

  task automatic run_frame(input int len, input bit glitch);
    int target;
    target = done_cnt + 1;
    exp_q.push_back(model(len));
    start_frame(len);
    wait_cyc(5);
    drive_bits(glitch);
    drive_stop();
    wait_done(target);
  endtask

  // Monitor: every rx_done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && rx_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'(rx_done), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_data", 64'(rx_data), mon_e.data);
        check("rx_bits", 64'(rx_bits), 64'(mon_e.bits));
        check("rx_err",  64'(rx_err),  64'(mon_e.err));
      end
    end
  end

  initial begin
    exp_t e;
    int   len, kind, n, target;

    wait_cyc(3);
    check("reset_busy", 64'(rx_busy), 64'd0);
    check("reset_done", 64'(rx_done), 64'd0);
    check("reset_data", 64'(rx_data), 64'd0);
    rst_n = 1'b1;
    wait_cyc(10);

    // Test 1: 1,0,0,0,0,0,0,1 -> 8'h81.
    frame_lo = '{25, 75, 75, 75, 75, 75, 75, 25};
    frame_hi = '{75, 25, 25, 25, 25, 25, 25, 75};
    stop_len = 50;
    run_frame(8, 1'b0);

    // Test 2: duty boundaries, tie decodes 0 -> 3'b010.
    frame_lo = '{55, 45, 50};
    frame_hi = '{45, 55, 50};
    stop_len = 50;
    run_frame(3, 1'b0);

    // Test 3: 32 expected, fourth bit high never ends -> data timeout, 3 bits.
    rand_pairs(4);
    stop_len = 0;
    run_frame(32, 1'b0);

    // Test 4: full 64-bit frame with a one-cycle glitch in every high phase.
    rand_pairs(64);
    stop_len = 50;
    run_frame(64, 1'b1);

    // Test 5: missing stop low, then stop low stuck for TO_CYC.
    rand_pairs(4);
    stop_len = 0;
    run_frame(4, 1'b0);
    rand_pairs(4);
    stop_len = 200;
    run_frame(4, 1'b0);

    // Zero-length request finishes immediately.
    frame_lo.delete();
    frame_hi.delete();
    stop_len = 0;
    run_frame(0, 1'b0);

    // Test 6a: abort in bit 5 -> idle next cycle, partial bits kept, no done.
    rand_pairs(4);
    stop_len = 1;
    e = model(16);
    target = done_cnt;
    start_frame(16);
    wait_cyc(5);
    drive_bits(1'b0);
    jb_rx = 1'b0;
    wait_cyc(10);
    rx_abort = 1'b1;
    tick();
    rx_abort = 1'b0;
    check("abort_busy", 64'(rx_busy), 64'd0);
    check("abort_bits", 64'(rx_bits), 64'(e.bits));
    check("abort_data", 64'(rx_data), e.data);
    jb_rx = 1'b1;
    wait_cyc(300);
    check("abort_no_done", 64'(done_cnt), 64'(target));

    // Restart while busy: only the second frame reports.
    rand_pairs(3);
    start_frame(8);
    wait_cyc(5);
    drive_bits(1'b0);
    wait_cyc(10);
    rand_pairs(5);
    stop_len = 40;
    run_frame(5, 1'b0);

    // Test 6b: asynchronous reset mid-frame.
    rand_pairs(2);
    start_frame(8);
    wait_cyc(5);
    drive_bits(1'b0);
    jb_rx = 1'b0;
    wait_cyc(7);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(rx_busy), 64'd0);
    check("rst_bits", 64'(rx_bits), 64'd0);
    check("rst_data", 64'(rx_data), 64'd0);
    check("rst_err",  64'(rx_err),  64'd0);
    jb_rx = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    exp_q.delete();
    wait_cyc(10);

    // Randomised frames: complete, or truncated (line left high).
    for (int f = 0; f < 12; f++) begin
      len  = int'($urandom_range(1, 24));
      kind = int'($urandom_range(0, 3));
      n    = (kind == 3) ? int'($urandom_range(1, len)) : len;
      rand_pairs(n);
      stop_len = (kind == 3) ? 0 : int'($urandom_range(20, 80));
      run_frame(len, f[0]);
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
